// File: rtl/ccm_ctr_stream_if.sv
// Stream, output and AES-request channels of the CCM counter-mode block.
// The DUT connects through the slave modport, the environment through master.
interface ccm_ctr_stream_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] input_data;
  logic             input_en;
  logic             input_last;
  logic             input_ready;

  logic [WIDTH-1:0] out_data;
  logic             out_en;
  logic             out_last;
  logic             out_ready;

  logic [127:0]     aes_block;
  logic             aes_en;
  logic             aes_ready;
  logic [127:0]     aes_result;
  logic             aes_result_en;

  modport master (
    output input_data, input_en, input_last, out_ready,
    output aes_ready, aes_result, aes_result_en,
    input  input_ready, out_data, out_en, out_last, aes_block, aes_en
  );

  modport slave (
    input  input_data, input_en, input_last, out_ready,
    input  aes_ready, aes_result, aes_result_en,
    output input_ready, out_data, out_en, out_last, aes_block, aes_en
  );
endinterface

// File: rtl/ccm_ctr_stream.sv
// CCM counter-mode stream engine: issues {flag, nonce, counter} blocks to a shared
// AES core, buffers returned keystream and XORs it onto the word stream.
//
// state | meaning
// IDLE  | waiting for start, no requests issued
// RUN   | accepting input words, prefetching keystream within credit limit
// PAD   | emitting the rest of the final block with zero input
// DRAIN | waiting for in-flight results and output register, then flush FIFO
module ccm_ctr_stream #(
  parameter int WIDTH       = 8,
  parameter int WIDTH_NONCE = 100,
  parameter int WIDTH_FLAG  = 8,
  parameter int WIDTH_COUNT = 20,
  parameter int KS_DEPTH    = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   pad_en,
  input  logic [WIDTH_NONCE-1:0] ccm_ctr_nonce,
  input  logic [WIDTH_FLAG-1:0]  ccm_ctr_flag,
  input  logic [WIDTH_COUNT-1:0] ccm_ctr_init,
  output logic                   busy,
  output logic                   ctr_wrap,
  ccm_ctr_stream_if.slave        bus
);

  localparam int WPB = 128 / WIDTH;
  localparam int IW  = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int PW  = (KS_DEPTH > 1) ? $clog2(KS_DEPTH) : 1;
  localparam int CW  = $clog2(KS_DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAD   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [WIDTH_FLAG-1:0]  flag_q, flag_d;
  logic [WIDTH_NONCE-1:0] nonce_q, nonce_d;
  logic [WIDTH_COUNT-1:0] ctr_q, ctr_d;
  logic                   pad_q, pad_d;
  logic                   wrap_q, wrap_d;
  logic                   aes_en_q, aes_en_d;
  logic [127:0]           aes_blk_q, aes_blk_d;
  logic [CW-1:0]          infl_q, infl_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [PW-1:0]          rd_q, rd_d;
  logic [PW-1:0]          wr_q, wr_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [WIDTH-1:0]       od_q, od_d;
  logic                   oe_q, oe_d;
  logic                   ol_q, ol_d;
  logic [127:0]           fifo_q [KS_DEPTH];

  logic [127:0]     head;
  logic [127:0]     ks_sh;
  logic [WIDTH-1:0] slice;
  logic             out_adv, fifo_ne, in_rdy, in_acc, pad_acc, adv;
  logic             blk_end, pop, push, xfer;

  always_comb begin
    head    = fifo_q[rd_q];
    ks_sh   = head << (idx_q * WIDTH);
    slice   = ks_sh[127 -: WIDTH];
    out_adv = !oe_q || bus.out_ready;
    fifo_ne = (cnt_q != '0);
    in_rdy  = (state_q == S_RUN) && fifo_ne && out_adv;
    in_acc  = in_rdy && bus.input_en;
    // Once the final padded word sits in the output register, stop emitting.
    pad_acc = (state_q == S_PAD) && fifo_ne && out_adv && !(oe_q && ol_q);
    adv     = in_acc || pad_acc;
    blk_end = (idx_q == IW'(WPB - 1));
    pop     = adv && blk_end;
    push    = bus.aes_result_en;
    xfer    = aes_en_q && bus.aes_ready;
  end

  always_comb begin
    state_d   = state_q;
    flag_d    = flag_q;
    nonce_d   = nonce_q;
    ctr_d     = ctr_q;
    pad_d     = pad_q;
    wrap_d    = wrap_q;
    aes_en_d  = aes_en_q;
    aes_blk_d = aes_blk_q;
    infl_d    = infl_q + CW'(xfer) - CW'(push);
    cnt_d     = cnt_q + CW'(push) - CW'(pop);
    rd_d      = rd_q;
    wr_d      = wr_q;
    idx_d     = idx_q;
    od_d      = od_q;
    oe_d      = oe_q;
    ol_d      = ol_q;

    if (xfer) begin
      ctr_d = ctr_q + 1'b1;
      if (&ctr_q) wrap_d = 1'b1;
    end
    if (push) wr_d = (wr_q == PW'(KS_DEPTH - 1)) ? '0 : wr_q + 1'b1;
    if (pop)  rd_d = (rd_q == PW'(KS_DEPTH - 1)) ? '0 : rd_q + 1'b1;

    if (adv) begin
      idx_d = blk_end ? '0 : idx_q + 1'b1;
      od_d  = (in_acc ? bus.input_data : '0) ^ slice;
      oe_d  = 1'b1;
      ol_d  = in_acc ? (bus.input_last && (!pad_q || blk_end)) : blk_end;
    end else if (bus.out_ready) begin
      oe_d = 1'b0;
      ol_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          flag_d  = ccm_ctr_flag;
          nonce_d = ccm_ctr_nonce;
          ctr_d   = ccm_ctr_init;
          pad_d   = pad_en;
          wrap_d  = 1'b0;
          idx_d   = '0;
        end
      end
      S_RUN: begin
        if (in_acc && bus.input_last)
          state_d = (pad_q && !blk_end) ? S_PAD : S_DRAIN;
      end
      S_PAD: begin
        if (oe_q && ol_q && bus.out_ready) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Surplus prefetched keystream is dropped here in one go.
        if (infl_q == '0 && !aes_en_q && !oe_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          rd_d    = '0;
          wr_d    = '0;
          idx_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pending request is held; a new one is raised only with a free credit.
    if (!aes_en_q || bus.aes_ready) begin
      aes_en_d = 1'b0;
      if (state_q == S_RUN && state_d == S_RUN &&
          ({1'b0, infl_d} + {1'b0, cnt_d}) < (CW + 1)'(KS_DEPTH)) begin
        aes_en_d  = 1'b1;
        aes_blk_d = {flag_q, nonce_q, ctr_d};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      flag_q    <= '0;
      nonce_q   <= '0;
      ctr_q     <= '0;
      pad_q     <= 1'b0;
      wrap_q    <= 1'b0;
      aes_en_q  <= 1'b0;
      aes_blk_q <= '0;
      infl_q    <= '0;
      cnt_q     <= '0;
      rd_q      <= '0;
      wr_q      <= '0;
      idx_q     <= '0;
      od_q      <= '0;
      oe_q      <= 1'b0;
      ol_q      <= 1'b0;
      for (int i = 0; i < KS_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      flag_q    <= flag_d;
      nonce_q   <= nonce_d;
      ctr_q     <= ctr_d;
      pad_q     <= pad_d;
      wrap_q    <= wrap_d;
      aes_en_q  <= aes_en_d;
      aes_blk_q <= aes_blk_d;
      infl_q    <= infl_d;
      cnt_q     <= cnt_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      idx_q     <= idx_d;
      od_q      <= od_d;
      oe_q      <= oe_d;
      ol_q      <= ol_d;
      if (push) fifo_q[wr_q] <= bus.aes_result;
    end
  end

  assign bus.input_ready = in_rdy;
  assign bus.out_data    = od_q;
  assign bus.out_en      = oe_q;
  assign bus.out_last    = ol_q;
  assign bus.aes_block   = aes_blk_q;
  assign bus.aes_en      = aes_en_q;
  assign busy            = (state_q != S_IDLE);
  assign ctr_wrap        = wrap_q;

endmodule

// File: tb/tb_ccm_ctr_stream.sv
// Bench for ccm_ctr_stream: 8-bit and 32-bit instances, each with an AES stub
// (result = block ^ mask, 3-cycle latency), checked against a keystream model.
module tb_ccm_ctr_stream;
  localparam logic [127:0] MASK = 128'hff00ff00ff00ff00ff00ff00ff00ff00;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, rst32, start8, start32, pad8, pad32;
  logic [99:0] nonce8, nonce32;
  logic [7:0]  flag8, flag32;
  logic [19:0] init8, init32;
  logic        busy8, busy32, wrap8, wrap32;

  ccm_ctr_stream_if #(.WIDTH(8))  i8 ();
  ccm_ctr_stream_if #(.WIDTH(32)) i32 ();

  ccm_ctr_stream #(.WIDTH(8)) u8 (
    .clk(clk), .reset(rst8), .start(start8), .pad_en(pad8),
    .ccm_ctr_nonce(nonce8), .ccm_ctr_flag(flag8), .ccm_ctr_init(init8),
    .busy(busy8), .ctr_wrap(wrap8), .bus(i8.slave));

  ccm_ctr_stream #(.WIDTH(32)) u32 (
    .clk(clk), .reset(rst32), .start(start32), .pad_en(pad32),
    .ccm_ctr_nonce(nonce32), .ccm_ctr_flag(flag32), .ccm_ctr_init(init32),
    .busy(busy32), .ctr_wrap(wrap32), .bus(i32.slave));

  // AES stubs: three-stage pipelines cleared by the shared reset
  logic [2:0]   v8, v32;
  logic [127:0] d8 [3];
  logic [127:0] d32 [3];
  always @(posedge clk) begin
    if (!rst8) begin
      v8 <= '0;
    end else begin
      v8 <= {v8[1:0], i8.aes_en & i8.aes_ready};
      d8[0] <= i8.aes_block ^ MASK; d8[1] <= d8[0]; d8[2] <= d8[1];
    end
    if (!rst32) begin
      v32 <= '0;
    end else begin
      v32 <= {v32[1:0], i32.aes_en & i32.aes_ready};
      d32[0] <= i32.aes_block ^ MASK; d32[1] <= d32[0]; d32[2] <= d32[1];
    end
  end
  assign i8.aes_result_en  = v8[2];
  assign i8.aes_result     = d8[2];
  assign i32.aes_result_en = v32[2];
  assign i32.aes_result    = d32[2];

  int total = 0;
  int bad = 0;
  logic [7:0]   msg [64];
  logic [7:0]   got [64];
  bit           gotlast [64];
  logic [7:0]   ref34 [34];
  logic [31:0]  msg32 [16];
  logic [31:0]  got32 [16];
  bit           last32 [16];
  logic [127:0] reqs [$];
  int nout;

  function automatic logic [7:0] ks8(logic [19:0] c, int k);
    logic [127:0] b;
    b = {flag8, nonce8, c} ^ MASK;
    return b[127 - k*8 -: 8];
  endfunction

  function automatic logic [31:0] ks32(logic [19:0] c, int k);
    logic [127:0] b;
    b = {flag32, nonce32, c} ^ MASK;
    return b[127 - k*32 -: 32];
  endfunction

  // Drive one 8-bit message with random handshakes and compare against the model.
  task automatic run8(input int n, input bit pad, input logic [19:0] init,
                      input int stall_at, input string name);
    int idx, cyc, scnt, en, nb;
    bit done, stalled;
    logic [7:0] held, exp;
    logic [19:0] c;
    idx = 0; cyc = 0; scnt = 0; done = 0; stalled = 0; nout = 0; held = '0;
    reqs.delete();
    @(negedge clk);
    pad8 = pad; init8 = init; start8 = 1'b1;
    while (!done && cyc < 3000) begin
      @(negedge clk);
      start8 = 1'b0;
      cyc++;
      if (stall_at >= 0 && !stalled && nout >= stall_at && i8.out_en) begin
        stalled = 1; scnt = 5; held = i8.out_data;
      end
      i8.input_en   = (idx < n) && ($urandom_range(0, 3) != 0);
      i8.input_data = (idx < n) ? msg[idx] : 8'h00;
      i8.input_last = (idx == n - 1);
      i8.out_ready  = (scnt > 0) ? 1'b0 : ((stall_at >= 0) ? 1'b1 : ($urandom_range(0, 3) != 0));
      i8.aes_ready  = ($urandom_range(0, 2) != 0);
      #1;
      if (scnt > 0) begin
        total++;
        if (i8.out_en !== 1'b1 || i8.out_data !== held) begin
          bad++;
          $display("FAIL %s stall_hold got en=%b data=%h want en=1 data=%h", name, i8.out_en, i8.out_data, held);
        end
        total++;
        if (i8.input_ready !== 1'b0) begin
          bad++;
          $display("FAIL %s stall_ready got %b want 0", name, i8.input_ready);
        end
        scnt--;
      end
      if (i8.input_en && i8.input_ready) idx++;
      if (i8.aes_en && i8.aes_ready) reqs.push_back(i8.aes_block);
      if (i8.out_en && i8.out_ready) begin
        if (nout < 64) begin
          got[nout] = i8.out_data;
          gotlast[nout] = i8.out_last;
        end
        nout++;
        if (i8.out_last) done = 1;
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout got words=%0d want out_last", name, nout);
    end
    i8.input_en = 1'b0;
    cyc = 0;
    while (busy8 && cyc < 100) begin
      @(negedge clk);
      i8.out_ready = 1'b1; i8.aes_ready = 1'b1;
      #1;
      if (i8.aes_en && i8.aes_ready) reqs.push_back(i8.aes_block);
      cyc++;
    end
    total++;
    if (busy8 !== 1'b0 || i8.out_en !== 1'b0) begin
      bad++;
      $display("FAIL %s idle_after got busy=%b out_en=%b want 0 0", name, busy8, i8.out_en);
    end
    en = pad ? ((n + 15) / 16) * 16 : n;
    total++;
    if (nout !== en) begin
      bad++;
      $display("FAIL %s word_count got %0d want %0d", name, nout, en);
    end
    for (int i = 0; i < en && i < nout && i < 64; i++) begin
      c = init + 20'(i / 16);
      exp = ((i < n) ? msg[i] : 8'h00) ^ ks8(c, i % 16);
      total++;
      if (got[i] !== exp || gotlast[i] !== (i == en - 1)) begin
        bad++;
        $display("FAIL %s word %0d got %h last=%b want %h last=%b", name, i, got[i], gotlast[i], exp, (i == en - 1));
      end
    end
    nb = (n + 15) / 16;
    for (int j = 0; j < nb; j++) begin
      total++;
      if (j >= reqs.size()) begin
        bad++;
        $display("FAIL %s request %0d missing, got %0d requests", name, j, reqs.size());
      end else if (reqs[j] !== {flag8, nonce8, init + 20'(j)}) begin
        bad++;
        $display("FAIL %s request %0d got %h want %h", name, j, reqs[j], {flag8, nonce8, init + 20'(j)});
      end
    end
  endtask

  task automatic test_reset();
    rst8 = 0; rst32 = 0; start8 = 0; start32 = 0; pad8 = 0; pad32 = 0;
    nonce8 = '0; nonce32 = '0; flag8 = '0; flag32 = '0; init8 = '0; init32 = '0;
    i8.input_data = '0; i8.input_en = 0; i8.input_last = 0; i8.out_ready = 0; i8.aes_ready = 0;
    i32.input_data = '0; i32.input_en = 0; i32.input_last = 0; i32.out_ready = 0; i32.aes_ready = 0;
    repeat (3) @(negedge clk);
    total++;
    if ({i8.out_en, i8.out_last, i8.aes_en, i8.input_ready, busy8, wrap8} !== 6'b0) begin
      bad++;
      $display("FAIL reset8_ctrl got %b want 000000", {i8.out_en, i8.out_last, i8.aes_en, i8.input_ready, busy8, wrap8});
    end
    total++;
    if (i8.out_data !== 8'h00 || i8.aes_block !== 128'h0) begin
      bad++;
      $display("FAIL reset8_data got %h/%h want 0/0", i8.out_data, i8.aes_block);
    end
    total++;
    if ({i32.out_en, i32.out_last, i32.aes_en, i32.input_ready, busy32, wrap32} !== 6'b0) begin
      bad++;
      $display("FAIL reset32_ctrl got %b want 000000", {i32.out_en, i32.out_last, i32.aes_en, i32.input_ready, busy32, wrap32});
    end
    rst8 = 1; rst32 = 1;
    repeat (2) @(negedge clk);
    total++;
    if (busy8 !== 1'b0 || i8.aes_en !== 1'b0) begin
      bad++;
      $display("FAIL idle_no_start got busy=%b aes_en=%b want 0 0", busy8, i8.aes_en);
    end
  endtask

  task automatic test_pad();
    flag8 = 8'($urandom);
    nonce8 = {$urandom, $urandom, $urandom, 4'($urandom)};
    for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
    run8(34, 1'b1, 20'h0, -1, "pad34");
    for (int i = 34; i < 48 && i < nout; i++) begin
      total++;
      if (got[i] !== ks8(20'd2, i - 32)) begin
        bad++;
        $display("FAIL pad34_ks2 byte %0d got %h want %h", i, got[i], ks8(20'd2, i - 32));
      end
    end
    for (int i = 0; i < 34; i++) ref34[i] = got[i];
  endtask

  task automatic test_nopad();
    run8(34, 1'b0, 20'h0, -1, "nopad34");
    for (int i = 0; i < 34 && i < nout; i++) begin
      total++;
      if (got[i] !== ref34[i]) begin
        bad++;
        $display("FAIL nopad_vs_pad byte %0d got %h want %h", i, got[i], ref34[i]);
      end
    end
  endtask

  task automatic test_aligned();
    for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
    run8(32, 1'b1, 20'h00123, -1, "aligned32");
  endtask

  task automatic test_stall();
    for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
    run8(40, 1'b1, 20'h00400, 5, "stall40");
  endtask

  task automatic test_wrap();
    flag8 = 8'($urandom);
    nonce8 = {$urandom, $urandom, $urandom, 4'($urandom)};
    for (int i = 0; i < 64; i++) msg[i] = 8'($urandom);
    run8(48, 1'b0, 20'hFFFFF, -1, "wrap48");
    total++;
    if (wrap8 !== 1'b1) begin
      bad++;
      $display("FAIL wrap_set got %b want 1", wrap8);
    end
    run8(4, 1'b0, 20'h0, -1, "after_wrap");
    total++;
    if (wrap8 !== 1'b0) begin
      bad++;
      $display("FAIL wrap_clear got %b want 0", wrap8);
    end
  endtask

  task automatic test_reset_mid32();
    int acc, cyc, idx, n;
    bit seen_last, done;
    logic [31:0] exp;
    flag32 = 8'($urandom);
    nonce32 = {$urandom, $urandom, $urandom, 4'($urandom)};
    acc = 0; cyc = 0; seen_last = 0;
    @(negedge clk);
    pad32 = 1'b0; init32 = 20'd3; start32 = 1'b1;
    while (acc < 5 && cyc < 300) begin
      @(negedge clk);
      start32 = 1'b0;
      i32.input_en = 1'b1; i32.input_data = $urandom; i32.input_last = 1'b0;
      i32.out_ready = 1'b1; i32.aes_ready = ($urandom_range(0, 1) != 0);
      #1;
      if (i32.input_en && i32.input_ready) acc++;
      if (i32.out_en && i32.out_last) seen_last = 1;
      cyc++;
    end
    total++;
    if (acc !== 5 || seen_last !== 1'b0) begin
      bad++;
      $display("FAIL mid32_prefix got accepted=%0d last=%b want 5 0", acc, seen_last);
    end
    @(negedge clk);
    rst32 = 1'b0; i32.input_en = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if ({i32.out_en, i32.out_last, i32.aes_en, i32.input_ready, busy32, wrap32} !== 6'b0) begin
      bad++;
      $display("FAIL mid32_reset_ctrl got %b want 000000", {i32.out_en, i32.out_last, i32.aes_en, i32.input_ready, busy32, wrap32});
    end
    total++;
    if (i32.out_data !== 32'h0 || i32.aes_block !== 128'h0) begin
      bad++;
      $display("FAIL mid32_reset_data got %h/%h want 0/0", i32.out_data, i32.aes_block);
    end
    @(negedge clk);
    rst32 = 1'b1;
    n = 8; idx = 0; nout = 0; cyc = 0; done = 0;
    for (int i = 0; i < 16; i++) msg32[i] = $urandom;
    reqs.delete();
    @(negedge clk);
    init32 = 20'd7; start32 = 1'b1;
    while (!done && cyc < 2000) begin
      @(negedge clk);
      start32 = 1'b0;
      cyc++;
      i32.input_en   = (idx < n) && ($urandom_range(0, 2) != 0);
      i32.input_data = (idx < n) ? msg32[idx] : 32'h0;
      i32.input_last = (idx == n - 1);
      i32.out_ready  = ($urandom_range(0, 3) != 0);
      i32.aes_ready  = ($urandom_range(0, 1) != 0);
      #1;
      if (i32.input_en && i32.input_ready) idx++;
      if (i32.aes_en && i32.aes_ready) reqs.push_back(i32.aes_block);
      if (i32.out_en && i32.out_ready) begin
        if (nout < 16) begin
          got32[nout] = i32.out_data;
          last32[nout] = i32.out_last;
        end
        nout++;
        if (i32.out_last) done = 1;
      end
    end
    i32.input_en = 1'b0;
    total++;
    if (!done || nout !== n) begin
      bad++;
      $display("FAIL fresh32_count got words=%0d done=%b want %0d 1", nout, done, n);
    end
    for (int i = 0; i < n && i < nout && i < 16; i++) begin
      exp = msg32[i] ^ ks32(20'd7 + 20'(i / 4), i % 4);
      total++;
      if (got32[i] !== exp || last32[i] !== (i == n - 1)) begin
        bad++;
        $display("FAIL fresh32 word %0d got %h last=%b want %h last=%b", i, got32[i], last32[i], exp, (i == n - 1));
      end
    end
    total++;
    if (reqs.size() == 0) begin
      bad++;
      $display("FAIL fresh32_first_req got none want counter 7");
    end else if (reqs[0] !== {flag32, nonce32, 20'd7}) begin
      bad++;
      $display("FAIL fresh32_first_req got %h want %h", reqs[0], {flag32, nonce32, 20'd7});
    end
  endtask

  initial begin
    test_reset();
    test_pad();
    test_nopad();
    test_aligned();
    test_stall();
    test_wrap();
    test_reset_mid32();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ccm_ctr_stream.md
Name: ccm_ctr_stream

Overview:
- Parametrised successor to the CCM counter-mode block; generalised data width, buffered keystream prefetch, and two-sided valid/ready flow control.
- Builds CCM counter blocks {flag, nonce, counter} and sends them to an external AES core over a handshake.
- XORs returned keystream with the input stream and optionally pads the final block.
- Sits between the CCM packet framer and the MAC/egress path; shares the AES core through its request port.

Parameters:
WIDTH, 8, data word width; one of 8/16/32/64/128.
WIDTH_NONCE, 100, nonce width.
WIDTH_FLAG, 8, flag width.
WIDTH_COUNT, 20, counter width; WIDTH_NONCE+WIDTH_FLAG+WIDTH_COUNT must equal 128.
KS_DEPTH, 2, keystream blocks buffered plus in flight (>=1).

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
start  in  1  pulse: latch config, begin message (ignored while busy)
pad_en  in  1  pad final partial block, sampled at start
ccm_ctr_nonce  in  WIDTH_NONCE  nonce, sampled at start
ccm_ctr_flag  in  WIDTH_FLAG  flag byte, sampled at start
ccm_ctr_init  in  WIDTH_COUNT  first counter value, sampled at start
input_data  in  WIDTH  plaintext/ciphertext word
input_en  in  1  input word valid
input_last  in  1  final input word, qualified by input_en
input_ready  out  1  block accepts a word this cycle
out_data  out  WIDTH  XORed word
out_en  out  1  output valid
out_last  out  1  final output word
out_ready  in  1  downstream accepts output
aes_block  out  128  counter block to AES
aes_en  out  1  AES request valid
aes_ready  in  1  AES accepts request
aes_result  in  128  keystream block, in request order
aes_result_en  in  1  keystream valid, one cycle
busy  out  1  state != IDLE
ctr_wrap  out  1  sticky: counter wrapped this message

Behaviour:
- Reset (reset=0 at posedge): state IDLE. All outputs 0, including aes_block. Counter, word index, credits and keystream FIFO cleared. The AES core shares this reset, so no stale results arrive afterwards. Reset mid-message aborts the message with no out_last.
- States: IDLE -> RUN on start. RUN -> PAD on accepted input_last when pad_en=1 and the word does not end a block. RUN -> DRAIN on accepted input_last otherwise. PAD -> DRAIN after the final padded word is accepted downstream. DRAIN -> IDLE once in-flight requests reach 0 and the output register is empty; the FIFO is flushed at that point.
- Counter block: aes_block = {flag, nonce, counter}, flag in the MSBs.
- aes_en rises in RUN when (in-flight + buffered) < KS_DEPTH. aes_en and aes_block are held until aes_ready.
- On each transfer: counter increments modulo 2^WIDTH_COUNT. If the counter was all-ones, ctr_wrap is set. ctr_wrap clears on start.
- No requests are issued in PAD/DRAIN/IDLE. Prefetched surplus keystream is discarded in DRAIN.
- aes_result_en pushes to the FIFO. Credit accounting makes overflow impossible.
- Word k of a block uses keystream bits [127-k*WIDTH -: WIDTH]. After word 128/WIDTH-1, the FIFO pops and the index returns to 0.
- input_ready = (state==RUN) & FIFO non-empty & (!out_en | out_ready).
- Accepted word: out_data <= input_data ^ slice, out_en <= 1 on the next cycle (latency 1).
- While out_en & !out_ready: out_data, out_en and out_last are held.
- PAD: emits the remaining words of the current block with zero input (out_data = slice), using the same output handshake.
- out_last goes high on the final word:
  - last padded word when pad_en=1;
  - the input_last word when pad_en=0 or the block is already aligned.
- Aligned messages get no extra block.
- start during busy is ignored. input_en outside RUN is ignored. input_last with no data is not supported (messages are at least 1 word).
- Simultaneous aes_result_en push and FIFO pop in one cycle: both take effect.

Test Plan:
- Bench AES stub: result = block ^ 128'hff00ff00ff00ff00ff00ff00ff00ff00, 3-cycle latency.
- WIDTH=8, pad_en=1, 34 bytes, init=0 -> 48 out bytes. Bytes 34..47 equal the keystream of counter 2. out_last on byte 47 only. Counters 0,1,2 consumed, busy drops after DRAIN.
- WIDTH=8, pad_en=0, same 34 bytes -> 34 out bytes, out_last on byte 33, bytes identical to the first 34 of the previous case.
- WIDTH=8, pad_en=1, 32 bytes -> exactly 32 out bytes, no padding block, out_last on byte 31.
- Hold out_ready=0 for 5 cycles mid-block -> out_data/out_en stable, input_ready=0, no word lost or duplicated. Output matches the golden sequence.
- WIDTH_COUNT=20, init=20'hFFFFF, 3 blocks -> aes_block counters FFFFF, 00000, 00001; ctr_wrap=1. Next start clears ctr_wrap.
- WIDTH=32, reset=0 after 5 accepted words -> next cycle all outputs 0, state IDLE. A fresh start with init=7 produces a correct message beginning at counter 7.
